// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the 8-bit up/down counter.
// Loads a start value, counts to a stop value, repeats the pass N times.
module counter_sweep_ctrl #(
   parameter int WIDTH  = 8,
   parameter int LOOP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  cfg_start,
   input  logic [WIDTH-1:0]  cfg_stop,
   input  logic              cfg_dir,
   input  logic [LOOP_W-1:0] cfg_loops,
   input  logic [WIDTH-1:0]  count,
   output logic              mode,
   output logic              clr,
   output logic              ld,
   output logic [WIDTH-1:0]  d_in,
   output logic              busy,
   output logic              done,
   output logic [LOOP_W-1:0] pass_cnt
);

   typedef enum logic [2:0] {
      S_CLR,
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0]  start_r;
   logic [WIDTH-1:0]  stop_r;
   logic              dir_r;
   logic [LOOP_W-1:0] loops_r;

   logic              at_stop;
   logic [LOOP_W:0]   passes_eff;
   logic [LOOP_W:0]   passes_next;
   logic              last_pass;
   logic              accept;

   assign at_stop     = (count == stop_r);
   assign passes_eff  = (loops_r == '0) ? {{LOOP_W{1'b0}}, 1'b1}
                                        : {1'b0, loops_r};
   assign passes_next = {1'b0, pass_cnt} + {{LOOP_W{1'b0}}, 1'b1};
   assign last_pass   = (passes_next >= passes_eff);
   assign accept      = (state == S_IDLE) && start && !abort;

   // State register; reset and abort both funnel through CLR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_CLR;
      else     state <= state_nx;
   end

   // Sweep configuration is captured once, when a sweep is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_r <= '0;
         stop_r  <= '0;
         dir_r   <= 1'b0;
         loops_r <= '0;
      end else if (accept) begin
         start_r <= cfg_start;
         stop_r  <= cfg_stop;
         dir_r   <= cfg_dir;
         loops_r <= cfg_loops;
      end
   end

   // Completed-pass counter; cleared on abort, in CLR and on a new sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt <= '0;
      end else if (abort || state == S_CLR || accept) begin
         pass_cnt <= '0;
      end else if (state == S_RUN && at_stop) begin
         pass_cnt <= pass_cnt + 1'b1;
      end
   end

   // Next-state and counter-control decode; hold is ld=1 with d_in=count.
   always_comb begin
      state_nx = state;
      mode     = 1'b0;
      clr      = 1'b0;
      ld       = 1'b0;
      d_in     = '0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_CLR: begin
            clr      = 1'b1;
            state_nx = S_IDLE;
         end
         S_IDLE: begin
            ld   = 1'b1;
            d_in = count;
            if (start) state_nx = S_LOAD;
         end
         S_LOAD: begin
            ld       = 1'b1;
            d_in     = start_r;
            busy     = 1'b1;
            state_nx = S_RUN;
         end
         S_RUN: begin
            mode = dir_r;
            busy = 1'b1;
            if (at_stop) begin
               ld       = 1'b1;
               d_in     = count;
               state_nx = last_pass ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            ld       = 1'b1;
            d_in     = count;
            state_nx = S_IDLE;
         end
         default: state_nx = S_CLR;
      endcase
      if (abort && state != S_CLR) state_nx = S_CLR;
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl with a behavioural counter in the loop.
// Expected per-cycle traces are queued at stimulus time and drained per cycle.
module tb_counter_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] cfg_start;
   logic [7:0] cfg_stop;
   logic       cfg_dir;
   logic [3:0] cfg_loops;
   logic [7:0] cnt;
   logic       mode;
   logic       clr;
   logic       ld;
   logic [7:0] d_in;
   logic       busy;
   logic       done;
   logic [3:0] pass_cnt;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       ld;
      logic       clr;
      logic       mode;
      logic [3:0] pass;
      logic [7:0] count;
   } obs_t;

   obs_t       obs;
   obs_t       q[$];
   obs_t       e;
   int         n_cmp;
   int         n_bad;
   logic [7:0] held;

   counter_sweep_ctrl #(.WIDTH(8), .LOOP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_dir   (cfg_dir),
      .cfg_loops (cfg_loops),
      .count     (cnt),
      .mode      (mode),
      .clr       (clr),
      .ld        (ld),
      .d_in      (d_in),
      .busy      (busy),
      .done      (done),
      .pass_cnt  (pass_cnt)
   );

   // Counter model: ld > clr > count, mode=1 counts up.
   always_ff @(posedge clk) begin
      if (ld)        cnt <= d_in;
      else if (clr)  cnt <= 8'd0;
      else if (mode) cnt <= cnt + 8'd1;
      else           cnt <= cnt - 8'd1;
   end

   assign obs = {busy, done, ld, clr, mode, pass_cnt, cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic obs_t mk(input logic b, input logic dn,
                               input logic l, input logic c,
                               input logic m, input logic [3:0] p,
                               input logic [7:0] v);
      return {b, dn, l, c, m, p, v};
   endfunction

   task automatic push_sweep(input logic [7:0] s, input logic [7:0] t,
                             input logic d, input logic [3:0] loops,
                             input int idle_n);
      logic [7:0] diff;
      logic [7:0] v;
      int         len;
      int         n;
      n    = (loops == 4'd0) ? 1 : int'(loops);
      diff = d ? (t - s) : (s - t);
      len  = int'(diff) + 1;
      for (int p = 0; p < n; p++) begin
         q.push_back(mk(1, 0, 1, 0, 0, 4'(p), (p == 0) ? held : t));
         for (int k = 0; k < len; k++) begin
            v = d ? (s + 8'(k)) : (s - 8'(k));
            q.push_back(mk(1, 0, (k == len - 1), 0, d, 4'(p), v));
         end
      end
      q.push_back(mk(0, 1, 1, 0, 0, 4'(n), t));
      for (int i = 0; i < idle_n; i++)
         q.push_back(mk(0, 0, 1, 0, 0, 4'(n), t));
      held = t;
   endtask

   task automatic kick(input logic [7:0] s, input logic [7:0] t,
                       input logic d, input logic [3:0] loops);
      @(negedge clk);
      cfg_start = s;
      cfg_stop  = t;
      cfg_dir   = d;
      cfg_loops = loops;
      start     = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (obs !== mk(0, 0, 0, 1, 0, 4'd0, cnt) || d_in !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got %h d_in %h want %h d_in 00",
                  obs, d_in, mk(0, 0, 0, 1, 0, 4'd0, cnt));
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      e = mk(0, 0, 1, 0, 0, 4'd0, 8'd0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL reset_idle got %h want %h", obs, e);
      end
      held = 8'd0;
   endtask

   task automatic test_up_sweep();
      kick(8'd10, 8'd14, 1'b1, 4'd1);
      push_sweep(8'd10, 8'd14, 1'b1, 4'd1, 2);
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL up_sweep got %h want %h", obs, e);
         end
      end
   endtask

   task automatic test_down_wrap();
      kick(8'd2, 8'd254, 1'b0, 4'd2);
      push_sweep(8'd2, 8'd254, 1'b0, 4'd2, 2);
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL down_wrap got %h want %h", obs, e);
         end
      end
   endtask

   task automatic test_single_step();
      kick(8'd7, 8'd7, 1'b1, 4'd0);
      push_sweep(8'd7, 8'd7, 1'b1, 4'd0, 20);
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL single_step got %h want %h", obs, e);
         end
      end
   endtask

   task automatic test_abort();
      int i;
      kick(8'd20, 8'd40, 1'b1, 4'd1);
      q.push_back(mk(1, 0, 1, 0, 0, 4'd0, held));
      for (int k = 0; k <= 10; k++)
         q.push_back(mk(1, 0, 0, 0, 1, 4'd0, 8'd20 + 8'(k)));
      q.push_back(mk(0, 0, 0, 1, 0, 4'd0, 8'd31));
      q.push_back(mk(0, 0, 1, 0, 0, 4'd0, 8'd0));
      q.push_back(mk(0, 0, 0, 1, 0, 4'd0, 8'd0));
      q.push_back(mk(0, 0, 1, 0, 0, 4'd0, 8'd0));
      q.push_back(mk(0, 0, 1, 0, 0, 4'd0, 8'd0));
      i = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL abort[%0d] got %h want %h", i, obs, e);
         end
         if (i == 11 || i == 13) begin
            abort = 1'b1;
            start = 1'b1;
         end
         i++;
      end
      held = 8'd0;
   endtask

   task automatic test_back_to_back();
      int i;
      kick(8'd100, 8'd103, 1'b1, 4'd2);
      push_sweep(8'd100, 8'd103, 1'b1, 4'd2, 2);
      i = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e || (ld && clr)) begin
            n_bad++;
            $display("FAIL back_to_back[%0d] got %h want %h", i, obs, e);
         end
         if (i == 3 || i == 7) begin
            start     = 1'b1;
            cfg_start = 8'd5;
            cfg_stop  = 8'd9;
            cfg_dir   = 1'b0;
            cfg_loops = 4'd3;
         end
         i++;
      end
   endtask

   task automatic test_async_rst();
      kick(8'd50, 8'd60, 1'b1, 4'd1);
      q.push_back(mk(1, 0, 1, 0, 0, 4'd0, held));
      for (int k = 0; k < 3; k++)
         q.push_back(mk(1, 0, 0, 0, 1, 4'd0, 8'd50 + 8'(k)));
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         e = q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL async_rst_run got %h want %h", obs, e);
         end
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      e = mk(0, 0, 0, 1, 0, 4'd0, 8'd52);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL async_rst_now got %h want %h", obs, e);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      e = mk(0, 0, 1, 0, 0, 4'd0, 8'd0);
      if (obs !== e) begin
         n_bad++;
         $display("FAIL async_rst_idle got %h want %h", obs, e);
      end
      held = 8'd0;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      held      = 8'd0;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_start = 8'd0;
      cfg_stop  = 8'd0;
      cfg_dir   = 1'b0;
      cfg_loops = 4'd0;
      test_reset();
      test_up_sweep();
      test_down_wrap();
      test_single_step();
      test_abort();
      test_back_to_back();
      test_async_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
